// File: rtl/cpu_loader.sv
// cpu_loader: boots a cpu from a byte stream, runs it, then dumps data memory.
// Frame (big-endian): NI, NI instr words, ND, ND data words, RUN(32), NR(16).
module cpu_loader #(
    parameter int IMEM_ADDR_W = 9,
    parameter int DMEM_ADDR_W = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] imem_addr,
    output logic        imem_wen,
    output logic [31:0] imem_wdata,
    output logic [31:0] dmem_addr,
    output logic        dmem_wen,
    output logic        dmem_ren,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    output logic        cpu_enable,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [31:0] ICAP = 32'd1 << IMEM_ADDR_W;
    localparam logic [31:0] DCAP = 32'd1 << DMEM_ADDR_W;

    typedef enum logic [3:0] {
        S_HDR_I, S_LOAD_I, S_HDR_D, S_LOAD_D, S_HDR_RUN,
        S_HDR_DUMP, S_RUN, S_RD, S_CAP, S_TX, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  bcnt_q, bcnt_d;
    logic [23:0] sh_q, sh_d;
    logic [15:0] num_q, num_d;
    logic [15:0] k_q, k_d;
    logic [31:0] run_q, run_d;
    logic [15:0] nr_q, nr_d;
    logic [31:0] word_q, word_d;
    logic        iwen_q, iwen_d;
    logic [31:0] iaddr_q, iaddr_d;
    logic [31:0] idata_q, idata_d;
    logic        dwen_q, dwen_d;
    logic [31:0] daddr_q, daddr_d;
    logic [31:0] ddata_q, ddata_d;
    logic        err_q, err_d;

    logic        acc;
    logic [31:0] in_word;
    logic [15:0] in_half;
    logic [15:0] k_inc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_HDR_I;
            bcnt_q  <= '0;
            sh_q    <= '0;
            num_q   <= '0;
            k_q     <= '0;
            run_q   <= '0;
            nr_q    <= '0;
            word_q  <= '0;
            iwen_q  <= 1'b0;
            iaddr_q <= '0;
            idata_q <= '0;
            dwen_q  <= 1'b0;
            daddr_q <= '0;
            ddata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            sh_q    <= sh_d;
            num_q   <= num_d;
            k_q     <= k_d;
            run_q   <= run_d;
            nr_q    <= nr_d;
            word_q  <= word_d;
            iwen_q  <= iwen_d;
            iaddr_q <= iaddr_d;
            idata_q <= idata_d;
            dwen_q  <= dwen_d;
            daddr_q <= daddr_d;
            ddata_q <= ddata_d;
            err_q   <= err_d;
        end
    end

    assign acc     = in_valid & in_ready;
    assign in_word = {sh_q, in_data};
    assign in_half = in_word[15:0];
    assign k_inc   = k_q + 16'd1;

    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        sh_d    = sh_q;
        num_d   = num_q;
        k_d     = k_q;
        run_d   = run_q;
        nr_d    = nr_q;
        word_d  = word_q;
        iwen_d  = 1'b0;
        iaddr_d = iaddr_q;
        idata_d = idata_q;
        dwen_d  = 1'b0;
        daddr_d = daddr_q;
        ddata_d = ddata_q;
        err_d   = err_q;
        if (acc) begin
            sh_d   = in_word[23:0];
            bcnt_d = bcnt_q + 2'd1;
        end
        unique case (state_q)
            S_HDR_I: if (acc && bcnt_q == 2'd1) begin
                num_d   = in_half;
                k_d     = '0;
                state_d = (in_half == '0) ? S_HDR_D : S_LOAD_I;
            end
            // Overflowing words are consumed but never written.
            S_LOAD_I: if (acc && bcnt_q == 2'd3) begin
                if ({16'd0, k_q} < ICAP) begin
                    iwen_d  = 1'b1;
                    iaddr_d = {14'd0, k_q, 2'b00};
                    idata_d = in_word;
                end else begin
                    err_d = 1'b1;
                end
                k_d = k_inc;
                if (k_inc == num_q) state_d = S_HDR_D;
            end
            S_HDR_D: if (acc && bcnt_q == 2'd1) begin
                num_d   = in_half;
                k_d     = '0;
                state_d = (in_half == '0) ? S_HDR_RUN : S_LOAD_D;
            end
            S_LOAD_D: if (acc && bcnt_q == 2'd3) begin
                if ({16'd0, k_q} < DCAP) begin
                    dwen_d  = 1'b1;
                    daddr_d = {14'd0, k_q, 2'b00};
                    ddata_d = in_word;
                end else begin
                    err_d = 1'b1;
                end
                k_d = k_inc;
                if (k_inc == num_q) state_d = S_HDR_RUN;
            end
            S_HDR_RUN: if (acc && bcnt_q == 2'd3) begin
                run_d   = in_word;
                state_d = S_HDR_DUMP;
            end
            S_HDR_DUMP: if (acc && bcnt_q == 2'd1) begin
                nr_d = in_half;
                k_d  = '0;
                if (run_q != '0)         state_d = S_RUN;
                else if (in_half != '0)  state_d = S_RD;
                else                     state_d = S_DONE;
            end
            S_RUN: begin
                run_d = run_q - 32'd1;
                if (run_q == 32'd1) state_d = (nr_q != '0) ? S_RD : S_DONE;
            end
            S_RD:  state_d = S_CAP;
            S_CAP: begin
                word_d  = dmem_rdata;
                state_d = S_TX;
            end
            S_TX: if (out_ready) begin
                word_d = {word_q[23:0], 8'h00};
                bcnt_d = bcnt_q + 2'd1;
                if (bcnt_q == 2'd3) begin
                    k_d     = k_inc;
                    state_d = (k_inc == nr_q) ? S_DONE : S_RD;
                end
            end
            S_DONE: ;
            default: state_d = S_HDR_I;
        endcase
        if (state_d != state_q) bcnt_d = '0;
    end

    always_comb begin
        in_ready   = (state_q == S_HDR_I)   || (state_q == S_LOAD_I) ||
                     (state_q == S_HDR_D)   || (state_q == S_LOAD_D) ||
                     (state_q == S_HDR_RUN) || (state_q == S_HDR_DUMP);
        cpu_enable = (state_q == S_RUN);
        dmem_ren   = (state_q == S_RD);
        out_valid  = (state_q == S_TX);
        out_data   = out_valid ? word_q[31:24] : 8'h00;
        dmem_addr  = dmem_ren ? {14'd0, k_q, 2'b00} : daddr_q;
        busy       = (state_q != S_DONE);
        done       = (state_q == S_DONE);
        imem_wen   = iwen_q;
        imem_addr  = iaddr_q;
        imem_wdata = idata_q;
        dmem_wen   = dwen_q;
        dmem_wdata = ddata_q;
        err        = err_q;
    end

endmodule

// File: tb/tb_cpu_loader.sv
// Directed bench for cpu_loader: frame-level model plus a per-cycle checker.
// The bench also stands in for the cpu's data/instruction memories.
module tb_cpu_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] imem_addr, imem_wdata, dmem_addr, dmem_wdata;
    logic [31:0] dmem_rdata = 32'h0;
    logic        imem_wen, dmem_wen, dmem_ren;
    logic        cpu_enable, busy, done, err;

    cpu_loader #(.IMEM_ADDR_W(9), .DMEM_ADDR_W(10)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .imem_addr(imem_addr), .imem_wen(imem_wen), .imem_wdata(imem_wdata),
        .dmem_addr(dmem_addr), .dmem_wen(dmem_wen), .dmem_ren(dmem_ren),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
        .cpu_enable(cpu_enable), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    logic [31:0] dmem [1024];
    logic [31:0] imem [512];

    always @(posedge clk) begin
        if (dmem_wen) dmem[dmem_addr[11:2]] <= dmem_wdata;
        if (dmem_ren) dmem_rdata <= dmem[dmem_addr[11:2]];
        if (imem_wen) imem[imem_addr[10:2]] <= imem_wdata;
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        int          bi;
    } wr_t;

    wr_t         exp_iw[$], exp_dw[$], ew;
    logic [7:0]  exp_out[$], got_out[$], frm[$];
    logic [31:0] ins[$], dat[$];
    logic [31:0] gold_d [1024];
    int          acc_cyc[$];
    int          cyc = 0;
    int          npass = 0, ntot = 0;
    int          en_cnt = 0, en_first = 0, en_last = 0;
    int          iw_cnt = 0, dw_cnt = 0;
    bit          rrdy = 1'b0;
    logic        prev_ov = 1'b0, prev_or = 1'b0;
    logic [7:0]  prev_od = 8'h00;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Acceptance time of every frame byte, as seen at the following negedge.
    always @(posedge clk)
        if (!rst && in_valid && in_ready) acc_cyc.push_back(cyc + 1);

    always @(posedge clk) begin
        #1;
        out_ready = rrdy ? 1'($urandom_range(1, 0)) : 1'b1;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (imem_wen | dmem_wen | dmem_ren | cpu_enable)
                chk("strobe_onehot",
                    $onehot({imem_wen, dmem_wen, dmem_ren, cpu_enable}), 1);
            if (imem_wen) begin
                iw_cnt++;
                chk("imem_expected", exp_iw.size() != 0, 1);
                if (exp_iw.size() != 0) begin
                    ew = exp_iw.pop_front();
                    chk("imem_addr", imem_addr, ew.a);
                    chk("imem_data", imem_wdata, ew.d);
                    if (ew.bi < acc_cyc.size())
                        chk("imem_latency", cyc, acc_cyc[ew.bi]);
                end
            end
            if (dmem_wen) begin
                dw_cnt++;
                chk("dmem_expected", exp_dw.size() != 0, 1);
                if (exp_dw.size() != 0) begin
                    ew = exp_dw.pop_front();
                    chk("dmem_addr", dmem_addr, ew.a);
                    chk("dmem_data", dmem_wdata, ew.d);
                    if (ew.bi < acc_cyc.size())
                        chk("dmem_latency", cyc, acc_cyc[ew.bi]);
                end
            end
            if (cpu_enable) begin
                if (en_cnt == 0) en_first = cyc;
                en_last = cyc;
                en_cnt++;
            end
            if (prev_ov && !prev_or)
                chk("out_hold", {out_valid, out_data}, {1'b1, prev_od});
            if (out_valid && out_ready) begin
                got_out.push_back(out_data);
                chk("out_expected", exp_out.size() != 0, 1);
                if (exp_out.size() != 0)
                    chk("out_byte", out_data, exp_out.pop_front());
            end
        end
        prev_ov = out_valid & ~rst;
        prev_or = out_ready;
        prev_od = out_data;
    end

    task automatic push_n(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) frm.push_back(v[8*i +: 8]);
    endtask

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
        int guard;
        bit a;
        if (gap > 0) begin
            in_valid = 1'b0;
            repeat ($urandom_range(gap, 0)) @(negedge clk);
        end
        in_data  = b;
        in_valid = 1'b1;
        guard    = 0;
        do begin
            a = in_ready;
            @(negedge clk);
            guard++;
        end while (!a && guard < 50);
        ok = a;
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst_imem_wen", imem_wen, 0);
        chk("rst_imem_addr", imem_addr, 0);
        chk("rst_imem_wdata", imem_wdata, 0);
        chk("rst_dmem_strobes", {dmem_wen, dmem_ren}, 0);
        chk("rst_dmem_addr", dmem_addr, 0);
        chk("rst_dmem_wdata", dmem_wdata, 0);
        chk("rst_out", {out_valid, out_data}, 0);
        chk("rst_enable", cpu_enable, 0);
        chk("rst_done_err", {done, err}, 0);
        chk("rst_busy", busy, 1);
        rst = 1'b0;
        acc_cyc.delete();
        got_out.delete();
        en_cnt = 0;
        iw_cnt = 0;
        dw_cnt = 0;
    endtask

    task automatic run_frame(input logic [31:0] run, input int nr,
                             input int gap, input bit rr);
        int          lbi, budget;
        bit          ok, exp_err;
        logic [31:0] w;
        frm.delete();
        exp_err = 1'b0;
        push_n(32'(ins.size()), 2);
        foreach (ins[k]) begin
            push_n(ins[k], 4);
            if (k < 512) exp_iw.push_back(wr_t'{32'(4 * k), ins[k], frm.size() - 1});
            else exp_err = 1'b1;
        end
        push_n(32'(dat.size()), 2);
        foreach (dat[k]) begin
            push_n(dat[k], 4);
            if (k < 1024) begin
                exp_dw.push_back(wr_t'{32'(4 * k), dat[k], frm.size() - 1});
                gold_d[k] = dat[k];
            end else exp_err = 1'b1;
        end
        push_n(run, 4);
        push_n(32'(nr), 2);
        lbi = frm.size() - 1;
        for (int j = 0; j < nr; j++) begin
            w = gold_d[j % 1024];
            for (int b = 3; b >= 0; b--) exp_out.push_back(w[8*b +: 8]);
        end
        rrdy = rr;
        foreach (frm[i]) begin
            send_byte(frm[i], gap, ok);
            if (!ok) begin
                chk("in_accept_timeout", ok, 1);
                break;
            end
        end
        in_valid = 1'b0;
        budget = 50 + int'(run) + nr * 60;
        while (!done && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        chk("done", done, 1);
        chk("busy_done", busy, 0);
        chk("in_ready_done", in_ready, 0);
        chk("err", err, exp_err);
        chk("enable_cycles", en_cnt, run);
        if (run != 0 && acc_cyc.size() > lbi) begin
            chk("enable_rise", en_first, acc_cyc[lbi]);
            chk("enable_contig", en_last - en_first + 1, run);
        end
        repeat (4) @(negedge clk);
        chk("done_hold", done, 1);
        chk("imem_left", exp_iw.size(), 0);
        chk("dmem_left", exp_dw.size(), 0);
        chk("out_left", exp_out.size(), 0);
        exp_iw.delete();
        exp_dw.delete();
        exp_out.delete();
        rrdy = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] lit [4];
        bit         ok;
        lit = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        for (int i = 0; i < 1024; i++) begin
            dmem[i]   = 32'h0;
            gold_d[i] = 32'h0;
        end

        // Two instruction words only.
        do_reset;
        ins = '{32'h20010005, 32'h20020007};
        dat.delete();
        run_frame(0, 0, 0, 0);
        chk("t1_imem0", imem[0], 32'h20010005);
        chk("t1_imem1", imem[1], 32'h20020007);
        chk("t1_writes", iw_cnt, 2);

        // One data word read back byte by byte.
        do_reset;
        ins.delete();
        dat = '{32'hDEADBEEF};
        run_frame(0, 1, 0, 0);
        chk("t2_dmem0", dmem[0], 32'hDEADBEEF);
        chk("t2_nbytes", got_out.size(), 4);
        if (got_out.size() == 4)
            for (int i = 0; i < 4; i++) chk("t2_byte", got_out[i], lit[i]);

        // Program, data, 20 run cycles, full dump.
        do_reset;
        ins.delete();
        dat.delete();
        for (int i = 0; i < 8; i++) ins.push_back(32'h00100013 + 32'(i << 20));
        for (int i = 0; i < 6; i++) dat.push_back(32'hA5000000 + 32'(i) * 32'h01010101);
        run_frame(20, 6, 0, 0);
        chk("t3_enable20", en_cnt, 20);

        // Instruction overflow: 513 words into a 512-word memory.
        do_reset;
        ins.delete();
        dat = '{32'h13572468, 32'h0F0F0F0F};
        for (int i = 0; i < 513; i++) ins.push_back(32'h10000000 | 32'(i));
        run_frame(3, 2, 0, 0);
        chk("t4_writes", iw_cnt, 512);
        chk("t4_err", err, 1);
        chk("t4_imem0", imem[0], 32'h10000000);
        chk("t4_imem511", imem[511], 32'h100001FF);

        // Gapped input and throttled output.
        do_reset;
        ins = '{32'h00A00093, 32'h00B00113, 32'h002081B3};
        dat = '{32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98, 32'h76543210};
        run_frame(5, 7, 3, 1);
        chk("t5_bytes", got_out.size(), 28);

        // Reset three bytes into the second instruction word.
        do_reset;
        frm.delete();
        push_n(32'd2, 2);
        push_n(32'hCAFE0001, 4);
        push_n(32'hCAFE0002, 4);
        exp_iw.push_back(wr_t'{32'h0, 32'hCAFE0001, 5});
        for (int i = 0; i < 9; i++) begin
            send_byte(frm[i], 0, ok);
            if (!ok) chk("t6_accept", ok, 1);
        end
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_word0_only", iw_cnt, 1);
        chk("t6_pending", exp_iw.size(), 0);
        exp_iw.delete();
        do_reset;
        chk("t6_no_write", iw_cnt, 0);
        ins = '{32'h0BAD0001, 32'h0BAD0002};
        dat = '{32'h55AA33CC};
        run_frame(1, 1, 1, 0);
        chk("t6_imem1", imem[1], 32'h0BAD0002);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule

// File: doc/cpu_loader.md
# cpu_loader

Boot and test-harness sequencer placed directly upstream of the `cpu` top. It takes a byte stream with a valid/ready handshake and writes a program image into instruction memory and an initial image into data memory through the cpu's external memory ports. It then holds `enable` high for a commanded number of cycles and streams a commanded number of data-memory words back out as bytes. It is the single driver of the cpu's `*_ext`, `*_ext_2` and `enable` inputs.

## Interface
- `IMEM_ADDR_W`, 9: instruction memory depth is 2^IMEM_ADDR_W words.
- `DMEM_ADDR_W`, 10: data memory depth is 2^DMEM_ADDR_W words.
- `clk` input 1: the single clock; all state updates on its rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `in_data` input 8: inbound frame byte.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: loader accepts the byte this cycle.
- `out_data` output 8: readback byte.
- `out_valid` output 1: `out_data` is valid.
- `out_ready` input 1: sink accepts the byte.
- `imem_addr` output 32: byte address to cpu `addr_ext`.
- `imem_wen` output 1: to cpu `wen_ext`.
- `imem_wdata` output 32: to cpu `wdata_ext`.
- `dmem_addr` output 32: byte address to cpu `addr_ext_2`.
- `dmem_wen` output 1: to cpu `wen_ext_2`.
- `dmem_ren` output 1: to cpu `ren_ext_2`.
- `dmem_wdata` output 32: to cpu `wdata_ext_2`.
- `dmem_rdata` input 32: from cpu `rdata_ext_2`.
- `cpu_enable` output 1: to cpu `enable`.
- `busy` output 1: state is not DONE.
- `done` output 1: sequence complete.
- `err` output 1: sticky capacity overflow.
- cpu `ren_ext` is tied 0 at the top level.

## Operation
- Frame format, all fields big-endian:
  - NI (16 bits), then NI instruction words (4 bytes each).
  - ND (16 bits), then ND data words.
  - RUN (32 bits).
  - NR (16 bits).
- States: HDR_I → LOAD_I → HDR_D → LOAD_D → HDR_RUN → HDR_DUMP → RUN → RD → TX → DONE.
- A LOAD state is skipped when its count is 0. RUN is skipped when RUN=0. RD/TX are skipped when NR=0.
- `in_ready`=1 only in HDR_* and LOAD_* states. A byte is accepted when `in_valid & in_ready`.
- A 2-bit byte counter assembles words; it is cleared on every state transition.
- Word k is written at byte address 4k, k = 0..N−1. The address counter is cleared on entry to each LOAD state.
- Capacity overflow: if k ≥ 2^IMEM_ADDR_W in LOAD_I (or k ≥ 2^DMEM_ADDR_W in LOAD_D):
  - the word is consumed, but no write is issued;
  - `err` is set and stays set until `rst`.
- RUN: `cpu_enable`=1 for exactly RUN cycles, counted by a 32-bit down-counter.
- Readback, word j = 0..NR−1 at address 4j:
  - RD: `dmem_ren` pulses 1 cycle; `dmem_rdata` is captured on the following cycle.
  - TX: the 4 bytes are emitted MSB first, one per `out_valid & out_ready`.
  - After the 4th byte, return to RD for the next word, or go to DONE.
  - Readback addresses ≥ capacity are not clamped; they wrap by the memory's own decode.
- DONE: `done`=1, `busy`=0, all strobes 0. Input is not accepted. Only `rst` restarts the sequence.
- `rst` clears the FSM to HDR_I, clears all counters, and drives every output to 0 except `busy`=1.
  - Memory contents are not cleared.
  - The cpu's own `arst_n` is not driven by this block.
  - A mid-frame `rst` discards the partial word; nothing further is written.

## Timing
- Write latency: when the 4th byte of a word is accepted in cycle t, `*_wen`=1 for cycle t+1 only. Address and wdata are stable in that cycle.
- Back-to-back bytes: the loader sustains 1 byte/cycle, so one write occurs every 4 cycles.
- Header-to-run: when the last NR byte is accepted in cycle t, `cpu_enable` rises in cycle t+1 and falls after RUN cycles.
- The RD phase starts the cycle after `cpu_enable` falls.
- Readback: `dmem_ren` at cycle t, capture at t+1, `out_valid`=1 from t+2.
- `out_data`/`out_valid` hold stable while `out_ready`=0.
- Minimum per readback word: 2 + 4 cycles.
- `*_wen`, `dmem_ren` and `cpu_enable` are never asserted in the same cycle.
- `in_ready` is combinational from state only and does not depend on `in_valid`.

## Test plan
- NI=2 words 0x20010005, 0x20020007; ND=0; RUN=0; NR=0 → `imem_wen` pulses at addr 0x0 and 0x4 with exact data; `done` rises; `err`=0.
- NI=0; ND=1 word 0xDEADBEEF; RUN=0; NR=1 → `dmem_wen` at addr 0; `out_data` sequence DE, AD, BE, EF; then `done`.
- Full program plus RUN=20 → `cpu_enable` high exactly 20 cycles; dumped dmem words match the golden model.
- NI=513 with IMEM_ADDR_W=9 → 512 writes, 513th word consumed without a write, `err`=1; the rest of the frame still completes.
- `out_ready` toggled randomly during readback, `in_valid` gapped during load → byte order and data unchanged, no duplicate or lost bytes.
- `rst` asserted after 3 bytes of the 2nd instruction word → no write for that word; all outputs 0 and `busy`=1 the next cycle; a fresh frame loads correctly.
